// File: rtl/mlp_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mlp_seq_pkg
//  Purpose  : Shared constants and FSM state encoding for the MLP layer
//             sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package mlp_seq_pkg;

  // Default largest legal layer count accepted from the header.
  localparam int MAX_LAYERS_DEF = 3;

  // Default RAM address width in bytes.
  localparam int ADDR_W_DEF = 15;

  // Sequencer states; explicit 4-bit encoding.
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_HDR1  = 4'd1,
    S_HDR2  = 4'd2,
    S_CHECK = 4'd3,
    S_LOAD  = 4'd4,
    S_ISSUE = 4'd5,
    S_WAIT  = 4'd6,
    S_NEXT  = 4'd7,
    S_DONE  = 4'd8,
    S_ERR   = 4'd9
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mlp_layer_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mlp_layer_sequencer_if
//  Purpose  : Bundles the UART receive stream, RAM write port, neuron job
//             handshake and result/status outputs of the layer sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface mlp_layer_sequencer_if #(
  parameter int ADDR_W = 15
);

  // UART receive side
  logic [7:0]        rx_data;
  logic              rx_valid;

  // RAM write port
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;

  // Neuron job handshake
  logic              neu_start;
  logic [ADDR_W-1:0] neu_in_base;
  logic [ADDR_W-1:0] neu_w_base;
  logic [7:0]        neu_len;
  logic              neu_done;
  logic [7:0]        neu_result;

  // Results and status
  logic              out_valid;
  logic [7:0]        out_data;
  logic              busy;
  logic              done;
  logic              err;

  // Sequencer side
  modport master (
    input  rx_data, rx_valid, neu_done, neu_result,
    output ram_we, ram_addr, ram_wdata,
    output neu_start, neu_in_base, neu_w_base, neu_len,
    output out_valid, out_data, busy, done, err
  );

  // Environment side (UART, RAM, neuron unit)
  modport slave (
    output rx_data, rx_valid, neu_done, neu_result,
    input  ram_we, ram_addr, ram_wdata,
    input  neu_start, neu_in_base, neu_w_base, neu_len,
    input  out_valid, out_data, busy, done, err
  );

endinterface
`default_nettype wire

// File: rtl/mlp_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : mlp_addr_gen
//  Purpose  : Combinational address arithmetic for the sequencer: total
//             load size, RAM footprint, and the input/weight/activation
//             addresses of neuron j in layer k.
//  Revision : 1.0 - initial release
// ============================================================================
module mlp_addr_gen #(
  parameter int ADDR_W = 15
) (
  input  logic [7:0]        n_i,
  input  logic [7:0]        h_i,
  input  logic [7:0]        l_i,
  input  logic [7:0]        k_i,
  input  logic [7:0]        j_i,
  output logic [ADDR_W+2:0] total_o,
  output logic [ADDR_W+2:0] need_o,
  output logic [ADDR_W-1:0] in_base_o,
  output logic [ADDR_W-1:0] w_base_o,
  output logic [ADDR_W-1:0] act_addr_o
);

  localparam int WW = ADDR_W + 3;
  localparam logic [WW-1:0] ONE = {{(WW-1){1'b0}}, 1'b1};

  logic [WW-1:0] n_w, h_w, l_w, k_w, j_w;
  logic [WW-1:0] hn_w, hh_w, l1_base_w;

  assign n_w = WW'(n_i);
  assign h_w = WW'(h_i);
  assign l_w = WW'(l_i);
  assign k_w = WW'(k_i);
  assign j_w = WW'(j_i);

  assign hn_w      = h_w * n_w;
  assign hh_w      = h_w * h_w;
  assign l1_base_w = n_w + hn_w;

  // Inputs + layer-0 weights + hidden-layer weights. L==0 wraps here but is
  // rejected by the header check before the value is ever used.
  assign total_o = l1_base_w + (l_w - ONE) * hh_w;

  // Loaded bytes plus room for every activation.
  assign need_o  = total_o + l_w * h_w;

  // Layer 0 reads the raw inputs; later layers read the previous layer's
  // activations, which sit right after the loaded image.
  assign in_base_o = (k_i == 8'd0) ? '0
                   : ADDR_W'(total_o + (k_w - ONE) * h_w);

  assign w_base_o  = (k_i == 8'd0) ? ADDR_W'(n_w + j_w * n_w)
                   : ADDR_W'(l1_base_w + (k_w - ONE) * hh_w + j_w * h_w);

  assign act_addr_o = ADDR_W'(total_o + k_w * h_w + j_w);

endmodule
`default_nettype wire

// File: rtl/mlp_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mlp_layer_sequencer
//  Purpose  : Top-level MLP controller. Parses the N/L/H header, loads the
//             input vector and weights into RAM, runs the neuron unit
//             neuron-by-neuron and layer-by-layer, writes activations back
//             and streams out the final layer.
//  Revision : 1.0 - initial release
// ============================================================================
module mlp_layer_sequencer
  import mlp_seq_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int MAX_LAYERS = MAX_LAYERS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  mlp_layer_sequencer_if.master bus
);

  localparam int WW = ADDR_W + 3;
  localparam logic [WW-1:0] ONE       = {{(WW-1){1'b0}}, 1'b1};
  localparam logic [WW-1:0] RAM_BYTES = {3'b001, {ADDR_W{1'b0}}};
  localparam logic [7:0]    MAX_L     = 8'(MAX_LAYERS);

  state_t            state_q, state_d;
  logic [7:0]        n_q, n_d, l_q, l_d, h_q, h_d;
  logic [7:0]        k_q, k_d, j_q, j_d;
  logic [WW-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0] in_base_q, in_base_d;
  logic [ADDR_W-1:0] w_base_q, w_base_d;
  logic [ADDR_W-1:0] act_q, act_d;
  logic [7:0]        len_q, len_d;

  logic [WW-1:0]     total_w, need_w;
  logic [ADDR_W-1:0] gen_in_base_w, gen_w_base_w, gen_act_w;
  logic              hdr_bad_w;

  // Addresses are generated for the job about to be issued (k_d/j_d) so
  // they can be registered as the FSM enters ISSUE.
  mlp_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .n_i        (n_q),
    .h_i        (h_q),
    .l_i        (l_q),
    .k_i        (k_d),
    .j_i        (j_d),
    .total_o    (total_w),
    .need_o     (need_w),
    .in_base_o  (gen_in_base_w),
    .w_base_o   (gen_w_base_w),
    .act_addr_o (gen_act_w)
  );

  assign hdr_bad_w = (n_q == 8'd0) || (h_q == 8'd0) || (l_q == 8'd0) ||
                     (l_q > MAX_L) || (need_w > RAM_BYTES);

  // Next-state, counters and strobes.
  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    l_d           = l_q;
    h_d           = h_q;
    k_d           = k_q;
    j_d           = j_q;
    ptr_d         = ptr_q;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = 8'd0;
    bus.neu_start = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          n_d     = bus.rx_data;
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (bus.rx_valid) begin
          l_d     = bus.rx_data;
          state_d = S_HDR2;
        end
      end
      S_HDR2: begin
        if (bus.rx_valid) begin
          h_d     = bus.rx_data;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (hdr_bad_w) begin
          state_d = S_ERR;
        end else begin
          ptr_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.rx_valid) begin
          bus.ram_we    = 1'b1;
          bus.ram_addr  = ptr_q[ADDR_W-1:0];
          bus.ram_wdata = bus.rx_data;
          ptr_d         = ptr_q + ONE;
          if (ptr_q == total_w - ONE) begin
            k_d     = 8'd0;
            j_d     = 8'd0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        bus.neu_start = 1'b1;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (bus.neu_done) begin
          bus.ram_we    = 1'b1;
          bus.ram_addr  = act_q;
          bus.ram_wdata = bus.neu_result;
          if (k_q == l_q - 8'd1) begin
            bus.out_valid = 1'b1;
            bus.out_data  = bus.neu_result;
          end
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (j_q + 8'd1 == h_q) begin
          j_d = 8'd0;
          k_d = k_q + 8'd1;
          state_d = (k_q + 8'd1 == l_q) ? S_DONE : S_ISSUE;
        end else begin
          j_d     = j_q + 8'd1;
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture job operands on entry to ISSUE and hold them through WAIT.
  always_comb begin
    in_base_d = in_base_q;
    w_base_d  = w_base_q;
    act_d     = act_q;
    len_d     = len_q;
    if (state_d == S_ISSUE) begin
      in_base_d = gen_in_base_w;
      w_base_d  = gen_w_base_w;
      act_d     = gen_act_w;
      len_d     = (k_d == 8'd0) ? n_q : h_q;
    end
  end

  // Status levels and registered job operands.
  always_comb begin
    bus.busy        = !(state_q inside {S_IDLE, S_DONE, S_ERR});
    bus.done        = (state_q == S_DONE);
    bus.err         = (state_q == S_ERR);
    bus.neu_in_base = in_base_q;
    bus.neu_w_base  = w_base_q;
    bus.neu_len     = len_q;
  end

  // State, header, counter and operand registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      n_q       <= 8'd0;
      l_q       <= 8'd0;
      h_q       <= 8'd0;
      k_q       <= 8'd0;
      j_q       <= 8'd0;
      ptr_q     <= '0;
      in_base_q <= '0;
      w_base_q  <= '0;
      act_q     <= '0;
      len_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      l_q       <= l_d;
      h_q       <= h_d;
      k_q       <= k_d;
      j_q       <= j_d;
      ptr_q     <= ptr_d;
      in_base_q <= in_base_d;
      w_base_q  <= w_base_d;
      act_q     <= act_d;
      len_q     <= len_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mlp_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mlp_layer_sequencer
//  Purpose  : Self-checking bench for mlp_layer_sequencer. A reference model
//             derives the RAM image, job list and expected outputs from the
//             header, and the DUT's writes/outputs are compared against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mlp_layer_sequencer;

  localparam int ADDR_W = 15;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mlp_layer_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  mlp_layer_sequencer #(.ADDR_W(ADDR_W), .MAX_LAYERS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [22:0] wr_q[$];
  logic [7:0]  out_q[$];

  // Record every RAM write and every output strobe.
  always @(negedge clk) begin
    if (bus.ram_we)    wr_q.push_back({bus.ram_addr, bus.ram_wdata});
    if (bus.out_valid) out_q.push_back(bus.out_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_start", bus.neu_start, 0);
  endtask

  // Full inference: header, image load, every neuron job, final checks.
  task automatic run_case(input int n, input int l, input int h,
                          input bit fixed, input bit inject);
    int total, ptr, c, d;
    bit found;
    logic [7:0] data, res;
    int exp_in[$], exp_w[$], exp_len[$], exp_act[$];
    bit exp_last[$];
    logic [22:0] exp_wr[$];
    logic [7:0]  exp_out[$];

    total = n + h * n + (l - 1) * h * h;
    // Weight rows are packed back to back after the inputs; walk them.
    ptr = n;
    for (int k = 0; k < l; k++) begin
      for (int j = 0; j < h; j++) begin
        exp_len.push_back(k == 0 ? n : h);
        exp_w.push_back(ptr);
        ptr += (k == 0 ? n : h);
        exp_in.push_back(k == 0 ? 0 : total + (k - 1) * h);
        exp_act.push_back(total + k * h + j);
        exp_last.push_back(k == l - 1);
      end
    end

    wr_q.delete();
    out_q.delete();
    send_byte(8'(n));
    send_byte(8'(l));
    send_byte(8'(h));
    tick();
    chk("busy_load", bus.busy, 1);

    for (int i = 0; i < total; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if (inject) begin
          bus.neu_result = 8'hEE;
          bus.neu_done   = 1'b1;
        end
        tick();
        bus.neu_done = 1'b0;
      end
      data = 8'($urandom_range(0, 255));
      exp_wr.push_back({ADDR_W'(i), data});
      send_byte(data);
    end

    for (int idx = 0; idx < exp_w.size(); idx++) begin
      found = 1'b0;
      c     = 0;
      for (int t = 0; t < 8; t++) begin
        @(negedge clk);
        if (bus.neu_start) begin
          found = 1'b1;
          c     = t;
          break;
        end
      end
      chk("start_seen", found, 1);
      if (!found) return;
      chk("start_latency", c, (idx == 0) ? 0 : 1);
      chk("in_base", bus.neu_in_base, exp_in[idx]);
      chk("w_base", bus.neu_w_base, exp_w[idx]);
      chk("len", bus.neu_len, exp_len[idx]);
      tick();
      d = $urandom_range(0, 2);
      for (int t = 0; t < d; t++) begin
        if (inject && t == 0) begin
          bus.rx_data  = 8'($urandom_range(0, 255));
          bus.rx_valid = 1'b1;
        end
        tick();
        bus.rx_valid = 1'b0;
      end
      chk("w_base_held", bus.neu_w_base, exp_w[idx]);
      chk("in_base_held", bus.neu_in_base, exp_in[idx]);
      res = fixed ? 8'(8'h11 * (idx + 1)) : 8'($urandom_range(0, 255));
      exp_wr.push_back({ADDR_W'(exp_act[idx]), res});
      if (exp_last[idx]) exp_out.push_back(res);
      bus.neu_result = res;
      bus.neu_done   = 1'b1;
      tick();
      bus.neu_done = 1'b0;
    end

    found = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (bus.done) begin
        found = 1'b1;
        break;
      end
    end
    chk("done_seen", found, 1);
    tick();
    chk("done_busy", bus.busy, 0);
    chk("done_err", bus.err, 0);

    // Bytes after completion must be ignored.
    send_byte(8'($urandom_range(0, 255)));
    tick();
    chk("done_sticky", bus.done, 1);

    chk("wr_count", wr_q.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
      chk("ram_write", wr_q[i], exp_wr[i]);
    chk("out_count", out_q.size(), exp_out.size());
    for (int i = 0; i < exp_out.size() && i < out_q.size(); i++)
      chk("out_data", out_q[i], exp_out[i]);
  endtask

  // Header that must be rejected.
  task automatic run_err(input int n, input int l, input int h);
    int total, need;
    bit exp_err;
    total   = n + h * n + (l - 1) * h * h;
    need    = total + l * h;
    exp_err = (n == 0) || (h == 0) || (l == 0) || (l > 3) || (need > 32768);
    wr_q.delete();
    send_byte(8'(n));
    send_byte(8'(l));
    send_byte(8'(h));
    tick();
    chk("err_flag", bus.err, exp_err);
    chk("err_busy", bus.busy, 0);
    chk("err_done", bus.done, 0);
    send_byte(8'($urandom_range(0, 255)));
    chk("err_sticky", bus.err, exp_err);
    chk("err_no_write", wr_q.size(), 0);
    do_reset();
  endtask

  initial begin
    bus.rx_data    = 8'd0;
    bus.rx_valid   = 1'b0;
    bus.neu_done   = 1'b0;
    bus.neu_result = 8'd0;
    tick();
    do_reset();
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_base", bus.neu_in_base, 0);
    chk("rst_w_base", bus.neu_w_base, 0);
    chk("rst_len", bus.neu_len, 0);

    // Single layer, known results 0x11 / 0x22.
    run_case(2, 1, 2, 1'b1, 1'b0);
    do_reset();

    // Two layers with spurious done/rx traffic.
    run_case(3, 2, 2, 1'b0, 1'b1);
    do_reset();

    // Illegal headers.
    run_err(2, 4, 2);
    run_err(255, 3, 255);
    run_err(0, 1, 1);
    run_err(3, 0, 2);
    run_err(3, 2, 0);
    run_err(int'($urandom_range(1, 8)), int'($urandom_range(4, 255)), int'($urandom_range(1, 8)));

    // Reset in the middle of LOAD; next byte must be taken as N.
    send_byte(8'd2);
    send_byte(8'd1);
    send_byte(8'd2);
    tick();
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    do_reset();
    run_case(2, 1, 2, 1'b0, 1'b0);
    do_reset();

    // Randomised networks.
    for (int r = 0; r < 6; r++) begin
      run_case(int'($urandom_range(1, 8)), int'($urandom_range(1, 3)),
               int'($urandom_range(1, 6)), 1'b0, 1'($urandom_range(0, 1)));
      do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mlp_layer_sequencer.md
Name: mlp_layer_sequencer

Overview:
- Top-level controller for the MLP core.
- Parses a 3-byte network header from the UART receive stream, then loads the input vector and all weights into the shared byte RAM.
- Sequences the single-neuron datapath neuron-by-neuron and layer-by-layer, writing each activation back to RAM.
- Streams final-layer activations out with a valid strobe. Sits between basic_uart (rx side), SPRAM and the slp neuron unit.

Parameters:
- ADDR_W, 15, RAM address width in bytes.
- MAX_LAYERS, 3, largest legal layer count.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  UART received byte.
- rx_valid  in  1  one-cycle strobe: rx_data valid.
- ram_we  out  1  RAM write enable, one cycle per write.
- ram_addr  out  ADDR_W  RAM write address.
- ram_wdata  out  8  RAM write data.
- neu_start  out  1  one-cycle pulse: neuron job begins.
- neu_in_base  out  ADDR_W  RAM base address of the neuron's input vector.
- neu_w_base  out  ADDR_W  RAM base address of the neuron's weight row.
- neu_len  out  8  input-vector length for the job.
- neu_done  in  1  one-cycle pulse: job finished.
- neu_result  in  8  activation; valid with neu_done.
- out_valid  out  1  one-cycle strobe per final-layer neuron.
- out_data  out  8  final activation.
- busy  out  1  high in every state except IDLE, DONE and ERR.
- done  out  1  level: inference complete.
- err  out  1  level: illegal header or memory overflow.

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs 0. Header registers and counters 0.
- Header bytes, in order:
  - N (input count, byte 0).
  - L (layer count, byte 1).
  - H (neurons per layer, byte 2).
  - Each is captured only on rx_valid: IDLE captures N, HDR1 captures L, HDR2 captures H.
- CHECK, one cycle, arithmetic at ADDR_W+3 bits:
  - TOTAL = N + H*N + (L-1)*H*H.
  - If N==0, H==0, L==0, L>MAX_LAYERS, or TOTAL + L*H > 2^ADDR_W: go to ERR.
  - Otherwise go to LOAD with the load pointer at 0.
- LOAD:
  - Each rx_valid produces ram_we=1, ram_addr=pointer, ram_wdata=rx_data in the same cycle.
  - The pointer increments after each write.
  - After byte TOTAL-1 is written, go to ISSUE with layer=0 and neuron=0.
- Memory layout:
  - Inputs occupy addresses 0..N-1.
  - Layer-0 weights start at N, row j at N + j*N.
  - Layer k>0 weights start at N + H*N + (k-1)*H*H, row j at that base + j*H.
  - Activation base ACT = TOTAL. Layer k neuron j is stored at ACT + k*H + j.
- ISSUE (one cycle):
  - neu_start=1.
  - neu_in_base = 0 for layer 0, else ACT + (k-1)*H.
  - neu_len = N for layer 0, else H.
  - neu_w_base per the layout above.
  - Bases and length are registered and held stable until neu_done. Go to WAIT.
- WAIT:
  - On neu_done: ram_we=1, ram_addr = ACT + k*H + j, ram_wdata = neu_result.
  - If k==L-1: out_valid=1 and out_data=neu_result in the same cycle.
  - Go to NEXT.
- NEXT:
  - j++. When j reaches H: j=0, k++.
  - When k reaches L: go to DONE. Otherwise go to ISSUE.
- Latency: 2 cycles from neu_done of one job to neu_start of the next.
- DONE and ERR: sticky until reset; done or err is held at 1.
- Extra-byte handling:
  - rx_valid outside IDLE/HDR1/HDR2/LOAD is ignored; no RAM write occurs.
  - neu_done outside WAIT is ignored.
- Reset asserted mid-LOAD or mid-WAIT: next cycle is IDLE, all strobes 0. RAM contents are not cleared.
- ram_we is never asserted in two states in the same cycle. LOAD and WAIT are mutually exclusive.

Decomposition:
- Package mlp_seq_pkg holds the state encoding constants (IDLE, HDR1, HDR2, CHECK, LOAD, ISSUE, WAIT, NEXT, DONE, ERR) and MAX_LAYERS.
- One sub-module, mlp_addr_gen: combinational computation of TOTAL, weight base, input base and activation address from N, H, k, j. This keeps the multipliers out of the FSM.

Test Plan:
- Header N=2, L=1, H=2, then 6 data bytes:
  - 6 writes at addresses 0..5.
  - neu_start with in_base=0, w_base=2, len=2; then w_base=4.
  - Model returns 0x11 and 0x22: RAM writes at 6 and 7, out_valid twice with 0x11 then 0x22, then done=1.
- Header N=3, L=2, H=2 (TOTAL=13):
  - Layer-1 jobs use in_base=13, len=2, w_base=9 then 11.
  - Activations are written at 13, 14, 15, 16.
  - out_valid fires only for the layer-1 results.
- Header L=4 -> err=1 one cycle after HDR2; no RAM writes; busy=0.
- Header N=255, L=3, H=255 -> err=1 (overflow).
- Reset pulsed after 3 LOAD bytes:
  - State returns to IDLE.
  - The next byte is treated as header N.
- Spurious neu_done during LOAD and an extra rx byte during WAIT: no RAM write, no state change.
